csa_encrypt_seq: RTL and testbench
==================================

// Module: csa_encrypt_seq
// PURPOSE
//  Packet-level DVB-CSA scrambling sequencer; the transmit-side counterpart of decypt.
//  Accepts one 188-byte TS packet byte-serially and stores it.
//  Runs the CSA block-cipher chain backwards over the payload, then the stream-cipher pass forwards.
//  Emits the scrambled packet byte-serially with TSC bits set.
//  Drives external block-encipher and stream-cipher cores through req/ack handshakes.
// PARAMETERS
//  PKT_BYTES  188  packet length in bytes (fixed by TS format)
//  BUF_AW     8    packet buffer address width
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   input byte valid
//  in_ready   out  1   sequencer accepts input byte
//  in_sop     in   1   first byte of packet (must be 0x47)
//  in_data    in   8   packet byte
//  key_sel    in   1   sampled with in_sop: 0 = even_cw, 1 = odd_cw
//  even_cw    in   64  even control word
//  odd_cw     in   64  odd control word
//  out_valid  out  1   output byte valid
//  out_ready  in   1   sink accepts output byte
//  out_sop    out  1   first output byte of packet
//  out_data   out  8   scrambled packet byte
//  be_req     out  1   block-encipher request; held until be_ack
//  be_key     out  64  block-cipher key
//  be_din     out  64  block plaintext
//  be_ack     in   1   one-cycle ack; be_dout valid in the same cycle
//  be_dout    in   64  block ciphertext
//  sc_init    out  1   one-cycle stream-cipher init pulse (key = be_key, iv = sc_iv)
//  sc_iv      out  64  IB_1 (first chained block)
//  sc_req     out  1   keystream request; held until sc_ack
//  sc_ack     in   1   one-cycle ack; sc_ks valid in the same cycle
//  sc_ks      in   64  next 8 keystream bytes, MSB first
//  busy       out  1   high from accepted in_sop until last output byte
// BEHAVIOUR
//  Reset values
//   - All outputs 0, except in_ready = 1.
//   - FSM returns to IDLE; buffer contents don't-care.
//  Key latch: key_sel is latched at the accepted in_sop; the chosen CW is held in be_key for the whole packet.
//  FSM states
//   - IDLE -> LOAD on accepted in_sop.
//   - LOAD: stores bytes 0..187 at addresses 0..187.
//     After byte 187: in_ready = 0, then go to PARSE.
//   - PARSE: one cycle.
//     - TSC = byte3[7:6], AFC = byte3[5:4].
//     - Payload start P = 4 for AFC = 01; P = 5 + byte4 for AFC = 11.
//     - Payload length L = 188 - P; blocks n = L/8; residue r = L%8.
//     - Passthrough (go to SEND, packet unchanged) if TSC != 00, AFC[0] = 0, P > 188, or n = 0.
//     - Otherwise go to CHAIN.
//   - CHAIN: reg = 0; for i = n down to 1: reg = E(DB_i ^ reg) via be_req.
//     - Result is written back as IB_i.
//   - SINIT: sc_iv = IB_1; pulse sc_init; SB_1 = IB_1.
//   - STREAM: for i = 2..n: SB_i = IB_i ^ ks.
//     - If r > 0: one extra sc_req; residue bytes XOR the top r keystream bytes; the remaining keystream bytes are discarded.
//   - SEND: byte3[7:6] is replaced by {1, key_sel}; bytes 0..187 are emitted in order.
//     - out_sop marks byte 0.
//     - out_data/out_valid are held stable while out_ready = 0.
//     - After byte 187 is accepted: go to IDLE, in_ready = 1 on the next cycle.
//  Input handshake
//   - A byte is accepted when in_valid & in_ready.
//   - in_sop outside IDLE is ignored in LOAD: byte count rules; a mid-packet in_sop is treated as data.
//   - A first byte != 0x47 is dropped and the FSM stays in IDLE.
//  Engine handshakes: be_req/sc_req rise only in their own state, are never dropped before ack, and are ignored if ack arrives while req = 0.
//  Latency (zero-wait engines, out_ready = 1): first out_sop no later than 188 + 1 + 2n + (n - 1 + (r > 0)) + 4 cycles after the last input byte.
//  Width rules: 8-byte blocks are big-endian, lowest buffer address = bits [63:56]; P, L, n and r are held in 8-bit unsigned registers.
//  Reset mid-operation: the packet is lost and no partial output continues after reset release.
// TESTING
//  1. AFC=01, TSC=00, payload bytes 0x00..0xB7, key_sel=0, engine model = identity E and ks = 0.
//     -> byte3 = 0x90; blocks are the backward XOR chain of payload; r = 0, n = 23.
//  2. AFC=11, byte4 = 3: L = 180, n = 22, r = 4.
//     -> exactly 22 be_req and 22 sc_req (21 + 1 residue); the last 4 bytes XOR ks[63:32].
//  3. TSC=10 on input, or AFC=10, or byte4 = 180 (P = 185, n = 0).
//     -> output bit-identical to input and zero be_req.
//  4. out_ready toggled 1-of-3 cycles and be_ack delayed 5 cycles with random CW and key_sel=1.
//     -> byte3[7:6] = 11 and output matches the golden C CSA model.
//  5. rst_n asserted during CHAIN, then a fresh packet is sent.
//     -> outputs 0 during reset, in_ready = 1 after release, and the second packet is correct.

Source files
------------

// File: rtl/csa_encrypt_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : csa_encrypt_seq_if
// Description : Byte streams, control words and cipher-engine handshakes
//               of the DVB-CSA packet scrambling sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface csa_encrypt_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sop;
    logic [7:0]  in_data;
    logic        key_sel;
    logic [63:0] even_cw;
    logic [63:0] odd_cw;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic [7:0]  out_data;
    logic        be_req;
    logic [63:0] be_key;
    logic [63:0] be_din;
    logic        be_ack;
    logic [63:0] be_dout;
    logic        sc_init;
    logic [63:0] sc_iv;
    logic        sc_req;
    logic        sc_ack;
    logic [63:0] sc_ks;
    logic        busy;

    // Sequencer side
    modport master (
        output in_ready, out_valid, out_sop, out_data,
               be_req, be_key, be_din, sc_init, sc_iv, sc_req, busy,
        input  in_valid, in_sop, in_data, key_sel, even_cw, odd_cw,
               out_ready, be_ack, be_dout, sc_ack, sc_ks
    );

    // Environment side: packet source/sink and cipher engines
    modport slave (
        input  in_ready, out_valid, out_sop, out_data,
               be_req, be_key, be_din, sc_init, sc_iv, sc_req, busy,
        output in_valid, in_sop, in_data, key_sel, even_cw, odd_cw,
               out_ready, be_ack, be_dout, sc_ack, sc_ks
    );
endinterface
`default_nettype wire

// File: rtl/csa_encrypt_seq.sv
`default_nettype none
// ============================================================================
// Module      : csa_encrypt_seq
// Description : Stores one TS packet, runs the CSA block chain backwards and
//               the stream pass forwards over its payload, then emits it.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_encrypt_seq #(
    parameter int PKT_BYTES = 188,
    parameter int BUF_AW    = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    csa_encrypt_seq_if.master bus
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_parse  = 3'd2;
    localparam logic [2:0] c_st_chain  = 3'd3;
    localparam logic [2:0] c_st_sinit  = 3'd4;
    localparam logic [2:0] c_st_stream = 3'd5;
    localparam logic [2:0] c_st_send   = 3'd6;

    localparam logic [7:0] c_last_addr = 8'(PKT_BYTES - 1);
    localparam logic [8:0] c_pkt_len   = 9'(PKT_BYTES);
    localparam logic [7:0] c_sync      = 8'h47;

    logic [2:0]  r_state;
    logic [2:0]  w_next;

    logic [7:0]  r_buf [0:(1 << BUF_AW) - 1];
    logic [7:0]  r_addr;
    logic        r_key_sel;
    logic [63:0] r_key;
    logic [7:0]  r_p;
    logic [7:0]  r_n;
    logic [7:0]  r_r;
    logic [7:0]  r_blk;
    logic        r_gap;
    logic [63:0] r_chain;
    logic [63:0] r_iv;
    logic        r_scr;

    logic        w_in_acc;
    logic        w_sop_ok;
    logic        w_be_ack;
    logic        w_sc_ack;
    logic        w_send_acc;
    logic [1:0]  w_tsc;
    logic [1:0]  w_afc;
    logic [8:0]  w_p9;
    logic [8:0]  w_l9;
    logic        w_pass;
    logic [7:0]  w_base;
    logic [63:0] w_blk;
    logic        w_stream_need;
    logic        w_stream_last;
    logic [7:0]  w_out_byte;

    assign w_in_acc   = bus.in_valid & bus.in_ready;
    assign w_sop_ok   = w_in_acc & bus.in_sop & (bus.in_data == c_sync);
    assign w_be_ack   = bus.be_ack & bus.be_req;
    assign w_sc_ack   = bus.sc_ack & bus.sc_req;
    assign w_send_acc = bus.out_valid & bus.out_ready;

    // Header decode; a negative payload length (P beyond the packet) shows up in w_l9[8]
    assign w_tsc  = r_buf[3][7:6];
    assign w_afc  = r_buf[3][5:4];
    assign w_p9   = (w_afc == 2'b11) ? (9'd5 + {1'b0, r_buf[4]}) : 9'd4;
    assign w_l9   = c_pkt_len - w_p9;
    assign w_pass = (w_tsc != 2'b00) | ~w_afc[0] | w_l9[8] | (w_l9[7:3] == 5'd0);

    // Block i (1-based) starts at P + 8*(i-1); the residue is block n+1
    assign w_base = r_p + 8'((r_blk - 8'd1) << 3);

    always_comb begin
        w_blk = '0;
        for (int j = 0; j < 8; j++) begin
            w_blk[63 - 8*j -: 8] = r_buf[w_base + 8'(j)];
        end
    end

    assign w_stream_need = (r_n > 8'd1) | (r_r != 8'd0);
    assign w_stream_last = (r_r == 8'd0) ? (r_blk == r_n) : (r_blk == r_n + 8'd1);

    always_comb begin
        w_out_byte = r_buf[r_addr];
        if (r_scr && (r_addr == 8'd3)) begin
            w_out_byte[7:6] = {1'b1, r_key_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:   if (w_sop_ok) w_next = c_st_load;
            c_st_load:   if (w_in_acc && (r_addr == c_last_addr)) w_next = c_st_parse;
            c_st_parse:  w_next = w_pass ? c_st_send : c_st_chain;
            c_st_chain:  if (w_be_ack && (r_blk == 8'd1)) w_next = c_st_sinit;
            c_st_sinit:  w_next = w_stream_need ? c_st_stream : c_st_send;
            c_st_stream: if (w_sc_ack && w_stream_last) w_next = c_st_send;
            c_st_send:   if (w_send_acc && (r_addr == c_last_addr)) w_next = c_st_idle;
            default:     w_next = c_st_idle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == c_st_idle) | (r_state == c_st_load);
        bus.busy      = (r_state != c_st_idle);
        bus.be_req    = (r_state == c_st_chain) & ~r_gap;
        bus.sc_req    = (r_state == c_st_stream) & ~r_gap;
        bus.sc_init   = (r_state == c_st_sinit);
        bus.be_key    = r_key;
        bus.sc_iv     = r_iv;
        bus.be_din    = '0;
        bus.out_valid = 1'b0;
        bus.out_sop   = 1'b0;
        bus.out_data  = 8'd0;
        if (r_state == c_st_chain) begin
            bus.be_din = w_blk ^ r_chain;
        end
        if (r_state == c_st_send) begin
            bus.out_valid = 1'b1;
            bus.out_sop   = (r_addr == 8'd0);
            bus.out_data  = w_out_byte;
        end
    end

    // Sequencing registers; r_gap idles each request for one cycle after its ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= 8'd0;
            r_key_sel <= 1'b0;
            r_key     <= '0;
            r_p       <= 8'd0;
            r_n       <= 8'd0;
            r_r       <= 8'd0;
            r_blk     <= 8'd0;
            r_gap     <= 1'b0;
            r_chain   <= '0;
            r_iv      <= '0;
            r_scr     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_sop_ok) begin
                        r_key_sel <= bus.key_sel;
                        r_key     <= bus.key_sel ? bus.odd_cw : bus.even_cw;
                        r_addr    <= 8'd1;
                    end
                end
                c_st_load: begin
                    if (w_in_acc) r_addr <= r_addr + 8'd1;
                end
                c_st_parse: begin
                    r_p     <= w_p9[7:0];
                    r_n     <= {3'd0, w_l9[7:3]};
                    r_r     <= {5'd0, w_l9[2:0]};
                    r_blk   <= {3'd0, w_l9[7:3]};
                    r_chain <= '0;
                    r_gap   <= 1'b0;
                    r_scr   <= ~w_pass;
                    r_addr  <= 8'd0;
                end
                c_st_chain: begin
                    r_gap <= w_be_ack;
                    if (w_be_ack) begin
                        r_chain <= bus.be_dout;
                        if (r_blk == 8'd1) begin
                            r_iv  <= bus.be_dout;
                            r_blk <= 8'd2;
                        end else begin
                            r_blk <= r_blk - 8'd1;
                        end
                    end
                end
                c_st_sinit: begin
                    r_gap <= 1'b0;
                end
                c_st_stream: begin
                    r_gap <= w_sc_ack;
                    if (w_sc_ack) r_blk <= r_blk + 8'd1;
                end
                c_st_send: begin
                    if (w_send_acc) r_addr <= r_addr + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Packet buffer: contents are don't-care after reset
    always_ff @(posedge clk) begin
        if ((r_state == c_st_idle) && w_sop_ok) begin
            r_buf[0] <= bus.in_data;
        end
        if ((r_state == c_st_load) && w_in_acc) begin
            r_buf[r_addr] <= bus.in_data;
        end
        if ((r_state == c_st_chain) && w_be_ack) begin
            for (int j = 0; j < 8; j++) begin
                r_buf[w_base + 8'(j)] <= bus.be_dout[63 - 8*j -: 8];
            end
        end
        if ((r_state == c_st_stream) && w_sc_ack) begin
            for (int j = 0; j < 8; j++) begin
                if ((r_blk <= r_n) || (8'(j) < r_r)) begin
                    r_buf[w_base + 8'(j)] <= r_buf[w_base + 8'(j)] ^ bus.sc_ks[63 - 8*j -: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csa_encrypt_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_encrypt_seq
// Description : Scoreboard bench for the CSA packet scrambling sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_encrypt_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csa_encrypt_seq_if bus ();

    csa_encrypt_seq #(.PKT_BYTES(188), .BUF_AW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    bit   ident = 1'b1;
    int   be_delay = 0;
    int   sc_delay = 0;
    int   rdy_mode = 0;
    int   be_cnt = 0;
    int   sc_cnt = 0;
    time  t_last = 0;
    time  t_sop  = 0;
    logic [8:0] sb_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Stand-in block cipher: any keyed bijective-looking mix serves for sequencing checks
    function automatic logic [63:0] ref_e(input logic [63:0] k, input logic [63:0] x);
        logic [63:0] t;
        if (ident) return x;
        t = x ^ k;
        t = {t[50:0], t[63:51]};
        t = t * 64'h9E3779B97F4A7C15;
        return t ^ (t >> 29) ^ k;
    endfunction

    function automatic logic [63:0] ref_ks(input logic [63:0] k, input logic [63:0] iv, input int idx);
        logic [63:0] t;
        if (ident) return 64'd0;
        t = (k ^ iv) + 64'(idx) * 64'hD1B54A32D192ED03;
        t = t * 64'hBF58476D1CE4E5B9;
        return t ^ (t >> 31);
    endfunction

    // Reference: scrambled packet from the header rules, chain and stream definitions
    task automatic build_exp(input logic [7:0] pkt [188], input bit ksel, input logic [63:0] cw,
                             output logic [7:0] exp [188], output int nb, output int nsc);
        int p, l, n, r;
        logic [63:0] ib [24];
        logic [63:0] db, ch, blk, ks;
        exp = pkt;
        nb  = 0;
        nsc = 0;
        p = (pkt[3][5:4] == 2'b11) ? 5 + int'(pkt[4]) : 4;
        if (pkt[3][7:6] != 2'b00 || pkt[3][4] == 1'b0 || p > 188) return;
        l = 188 - p;
        n = l / 8;
        r = l % 8;
        if (n == 0) return;
        ch = 64'd0;
        for (int i = n; i >= 1; i--) begin
            db = 64'd0;
            for (int j = 0; j < 8; j++) db = {db[55:0], pkt[p + 8*(i-1) + j]};
            ch = ref_e(cw, db ^ ch);
            ib[i] = ch;
        end
        for (int i = 1; i <= n; i++) begin
            blk = (i == 1) ? ib[1] : (ib[i] ^ ref_ks(cw, ib[1], i - 2));
            for (int j = 0; j < 8; j++) exp[p + 8*(i-1) + j] = blk[63 - 8*j -: 8];
        end
        if (r > 0) begin
            ks = ref_ks(cw, ib[1], n - 1);
            for (int j = 0; j < r; j++) exp[p + 8*n + j] = pkt[p + 8*n + j] ^ ks[63 - 8*j -: 8];
        end
        exp[3][7:6] = {1'b1, ksel};
        nb  = n;
        nsc = n - 1 + ((r > 0) ? 1 : 0);
    endtask

    // Block-encipher engine
    initial begin
        int cnt;
        cnt = 0;
        bus.be_ack  = 1'b0;
        bus.be_dout = 64'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.be_ack = 1'b0;
                cnt = 0;
            end else if (bus.be_ack) begin
                bus.be_ack = 1'b0;
                cnt = 0;
            end else if (bus.be_req) begin
                if (cnt >= be_delay) begin
                    bus.be_ack  = 1'b1;
                    bus.be_dout = ref_e(bus.be_key, bus.be_din);
                    be_cnt++;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Stream-cipher engine
    initial begin
        int cnt, idx;
        logic [63:0] k, iv;
        cnt = 0; idx = 0; k = 64'd0; iv = 64'd0;
        bus.sc_ack = 1'b0;
        bus.sc_ks  = 64'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.sc_ack = 1'b0;
                cnt = 0;
            end else begin
                if (bus.sc_init) begin
                    k = bus.be_key; iv = bus.sc_iv; idx = 0;
                end
                if (bus.sc_ack) begin
                    bus.sc_ack = 1'b0;
                    cnt = 0;
                end else if (bus.sc_req) begin
                    if (cnt >= sc_delay) begin
                        bus.sc_ack = 1'b1;
                        bus.sc_ks  = ref_ks(k, iv, idx);
                        idx++;
                        sc_cnt++;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // Output sink back-pressure
    initial begin
        int k;
        k = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            k++;
            bus.out_ready = (rdy_mode == 0) ? 1'b1 : ((k % 3) == 0);
        end
    end

    // Monitor: pops the scoreboard on every accepted output byte
    initial begin
        logic       stall;
        logic [7:0] hd;
        logic [8:0] e;
        stall = 1'b0; hd = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) check("hold_stable", 64'({bus.out_valid, bus.out_data}), 64'({1'b1, hd}));
                if (bus.out_valid && bus.out_sop && !stall) t_sop = $time;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output actual=%h required=none", bus.out_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_byte", 64'({bus.out_sop, bus.out_data}), 64'(e));
                    end
                    stall = 1'b0;
                end else begin
                    stall = bus.out_valid;
                    hd    = bus.out_data;
                end
            end
        end
    end

    task automatic make_pkt(input logic [1:0] tsc, input logic [1:0] afc, input int b4,
                            output logic [7:0] pkt [188]);
        for (int b = 0; b < 188; b++) pkt[b] = 8'($urandom);
        pkt[0] = 8'h47;
        pkt[3] = {tsc, afc, 4'($urandom)};
        if (b4 >= 0) pkt[4] = 8'(b4);
    endtask

    task automatic send_bytes(input logic [7:0] pkt [188], input bit gaps);
        for (int b = 0; b < 188; b++) begin
            int w;
            @(negedge clk);
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_sop   = (b == 0);
            bus.in_data  = pkt[b];
            w = 0;
            while (!bus.in_ready && w < 3000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 3000) check("in_ready_timeout", 64'(w), 64'(0));
        end
        @(posedge clk);
        t_last = $time;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || bus.busy) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        check("drain_in_time", 64'(w < 20000), 64'(1));
        @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'(1));
    endtask

    task automatic run_pkt(input logic [7:0] pkt [188], input bit ksel, input bit gaps);
        logic [7:0]  exp [188];
        logic [63:0] ecw, ocw;
        int nb, nsc, b0, s0;
        ecw = {$urandom, $urandom};
        ocw = {$urandom, $urandom};
        bus.even_cw = ecw;
        bus.odd_cw  = ocw;
        bus.key_sel = ksel;
        build_exp(pkt, ksel, ksel ? ocw : ecw, exp, nb, nsc);
        for (int b = 0; b < 188; b++) sb_q.push_back({b == 0, exp[b]});
        b0 = be_cnt;
        s0 = sc_cnt;
        send_bytes(pkt, gaps);
        wait_drain();
        check("be_req_count", 64'(be_cnt - b0), 64'(nb));
        check("sc_req_count", 64'(sc_cnt - s0), 64'(nsc));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pkt [188];
        int lat, w;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_data  = 8'd0;
        bus.key_sel  = 1'b0;
        bus.even_cw  = 64'd0;
        bus.odd_cw   = 64'd0;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_sop",   64'(bus.out_sop),   64'(0));
        check("rst_out_data",  64'(bus.out_data),  64'(0));
        check("rst_be_req",    64'(bus.be_req),    64'(0));
        check("rst_be_key",    bus.be_key,         64'(0));
        check("rst_be_din",    bus.be_din,         64'(0));
        check("rst_sc_init",   64'(bus.sc_init),   64'(0));
        check("rst_sc_iv",     bus.sc_iv,          64'(0));
        check("rst_sc_req",    64'(bus.sc_req),    64'(0));
        check("rst_busy",      64'(bus.busy),      64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Identity engines, counting payload, full 23-block chain
        ident = 1'b1;
        make_pkt(2'b00, 2'b01, -1, pkt);
        pkt[3] = 8'h10;
        for (int b = 4; b < 188; b++) pkt[b] = 8'(b - 4);
        run_pkt(pkt, 1'b0, 1'b0);
        lat = int'((t_sop - t_last) / 10);
        check("latency_bound", 64'(lat <= 188 + 1 + 46 + 22 + 4), 64'(1));

        // Adaptation field with residue
        ident = 1'b0;
        make_pkt(2'b00, 2'b11, 3, pkt);
        run_pkt(pkt, 1'($urandom), 1'b0);

        // Passthrough cases
        make_pkt(2'b10, 2'b01, -1, pkt);
        run_pkt(pkt, 1'b1, 1'b0);
        make_pkt(2'b00, 2'b10, -1, pkt);
        run_pkt(pkt, 1'b0, 1'b0);
        make_pkt(2'b00, 2'b11, 180, pkt);
        run_pkt(pkt, 1'b0, 1'b0);
        make_pkt(2'b00, 2'b11, 200, pkt);
        run_pkt(pkt, 1'b1, 1'b0);

        // Bad sync byte is dropped and nothing leaves
        make_pkt(2'b00, 2'b01, -1, pkt);
        pkt[0] = 8'h48;
        send_bytes(pkt, 1'b0);
        repeat (5) @(negedge clk);
        check("bad_sync_busy", 64'(bus.busy), 64'(0));

        // Back-pressure and slow engines, odd key
        rdy_mode = 1;
        be_delay = 5;
        sc_delay = 5;
        make_pkt(2'b00, 2'b01, -1, pkt);
        run_pkt(pkt, 1'b1, 1'b1);
        make_pkt(2'b00, 2'b11, int'($urandom_range(0, 20)), pkt);
        run_pkt(pkt, 1'b1, 1'b1);

        // Random headers
        for (int k = 0; k < 3; k++) begin
            be_delay = int'($urandom_range(0, 3));
            sc_delay = int'($urandom_range(0, 3));
            make_pkt(($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00, 2'($urandom),
                     int'($urandom_range(0, 200)), pkt);
            run_pkt(pkt, 1'($urandom), 1'b1);
        end

        // Reset in the middle of the block chain
        rdy_mode = 0;
        be_delay = 5;
        make_pkt(2'b00, 2'b01, -1, pkt);
        bus.key_sel = 1'b1;
        bus.odd_cw  = {$urandom, $urandom};
        send_bytes(pkt, 1'b0);
        w = 0;
        while (!bus.be_req && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("chain_reached", 64'(bus.be_req), 64'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_be_req",    64'(bus.be_req),    64'(0));
        check("mid_rst_be_key",    bus.be_key,         64'(0));
        check("mid_rst_busy",      64'(bus.busy),      64'(0));
        check("mid_rst_sc_req",    64'(bus.sc_req),    64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
        make_pkt(2'b00, 2'b11, 7, pkt);
        run_pkt(pkt, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
